instr_encoder: RTL

- Inverse of the single-cycle CPU's control decoder: accepts symbolic instructions (mnemonic code plus register/immediate/target fields) and emits 32-bit MIPS instruction words.
- Each emitted word is paired with a sequential instruction-memory byte address.
- Used as the on-chip program loader/self-test stimulus source feeding instruction memory ahead of the CPU.
- Valid/ready on both sides; one-entry registered output stage.

---
 rtl/instr_encoder_if.sv | 35 +++
 rtl/instr_encoder.sv | 108 ++++++++++
 2 files changed

// File: rtl/instr_encoder_if.sv
// Symbolic-instruction to instruction-memory-word bus.
// Input side:  in_valid/in_ready handshake carrying mnem, rs, rt, rd, imm,
//              target, plus the restart request.
// Output side: out_valid/out_ready handshake carrying word and word_addr,
//              plus the err pulse and the emitted-word count.
// master drives the symbolic side and consumes words; slave is the encoder.
interface instr_encoder_if #(
  parameter int ADDR_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [4:0]        mnem;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic [15:0]       imm;
  logic [25:0]       target;
  logic              restart;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       word;
  logic [ADDR_W-1:0] word_addr;
  logic              err;
  logic [15:0]       count;

  modport master (
    output in_valid, mnem, rs, rt, rd, imm, target, restart, out_ready,
    input  in_ready, out_valid, word, word_addr, err, count
  );

  modport slave (
    input  in_valid, mnem, rs, rt, rd, imm, target, restart, out_ready,
    output in_ready, out_valid, word, word_addr, err, count
  );
endinterface

// File: rtl/instr_encoder.sv
// instr_encoder: turns symbolic MIPS instructions into 32-bit instruction
// words, each tagged with a sequential instruction-memory byte address.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - instr_encoder_if.slave: symbolic input handshake, encoded word
//          output handshake, err pulse (illegal mnemonic consumed) and
//          saturating count of words emitted since reset/restart.
// One-entry registered output stage; a new word may be loaded on the same
// edge the held word is taken, so a steady stream runs at one word/cycle.
module instr_encoder #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0000_3000
) (
  input  logic            clk,
  input  logic            rst,
  instr_encoder_if.slave  bus
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t            state_reg;
  logic [31:0]       word_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [15:0]       count_reg;
  logic              err_reg;

  logic [31:0]       enc_word;
  logic              enc_legal;
  logic              accept;
  logic              handshake;

  // Combinational encoder. Fields a format does not use are built from
  // constants so nothing from the unused inputs can leak into the word.
  always_comb begin
    enc_word  = 32'h0;
    enc_legal = 1'b1;
    case (bus.mnem)
      5'd0:    enc_word = {6'b000000, bus.rs, bus.rt, bus.rd, 5'b0, 6'b100001}; // addu
      5'd1:    enc_word = {6'b000000, bus.rs, bus.rt, bus.rd, 5'b0, 6'b100011}; // subu
      5'd2:    enc_word = {6'b000000, bus.rs, bus.rt, bus.rd, 5'b0, 6'b100000}; // add
      5'd3:    enc_word = {6'b000000, bus.rs, bus.rt, bus.rd, 5'b0, 6'b100100}; // and
      5'd4:    enc_word = {6'b000000, bus.rs, bus.rt, bus.rd, 5'b0, 6'b100101}; // or
      5'd5:    enc_word = {6'b000000, bus.rs, bus.rt, bus.rd, 5'b0, 6'b101010}; // slt
      5'd6:    enc_word = {6'b000000, bus.rs, 15'b0, 6'b001000};                // jr
      5'd7:    enc_word = {6'b001000, bus.rs, bus.rt, bus.imm};                 // addi
      5'd8:    enc_word = {6'b001001, bus.rs, bus.rt, bus.imm};                 // addiu
      5'd9:    enc_word = {6'b001100, bus.rs, bus.rt, bus.imm};                 // andi
      5'd10:   enc_word = {6'b001101, bus.rs, bus.rt, bus.imm};                 // ori
      5'd11:   enc_word = {6'b001111, 5'b0, bus.rt, bus.imm};                   // lui
      5'd12:   enc_word = {6'b100011, bus.rs, bus.rt, bus.imm};                 // lw
      5'd13:   enc_word = {6'b101011, bus.rs, bus.rt, bus.imm};                 // sw
      5'd14:   enc_word = {6'b000100, bus.rs, bus.rt, bus.imm};                 // beq
      5'd15:   enc_word = {6'b000010, bus.target};                              // j
      5'd16:   enc_word = {6'b000011, bus.target};                              // jal
      default: enc_legal = 1'b0;
    endcase
  end

  // When FULL, a slot frees up only if the held word leaves on this edge.
  assign bus.in_ready  = (state_reg == EMPTY) || bus.out_ready;
  assign accept        = bus.in_valid && bus.in_ready;
  assign handshake     = (state_reg == FULL) && bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= EMPTY;
      word_reg  <= 32'h0;
      addr_reg  <= BASE_ADDR;
      count_reg <= 16'h0;
      err_reg   <= 1'b0;
    end else begin
      err_reg <= accept && !enc_legal;

      // addr_reg always names the slot of the word held (or next loaded),
      // so it advances only when a word actually leaves.
      if (handshake) begin
        addr_reg <= addr_reg + ADDR_W'(4);
        if (count_reg != 16'hFFFF) begin
          count_reg <= count_reg + 16'd1;
        end
      end

      if (accept && enc_legal) begin
        word_reg  <= enc_word;
        state_reg <= FULL;
      end else if (handshake) begin
        state_reg <= EMPTY;
      end

      // An illegal mnemonic still counts as an accept and blocks restart.
      if ((state_reg == EMPTY) && !accept && bus.restart) begin
        addr_reg  <= BASE_ADDR;
        count_reg <= 16'h0;
      end
    end
  end

  assign bus.out_valid = (state_reg == FULL);
  assign bus.word      = word_reg;
  assign bus.word_addr = addr_reg;
  assign bus.err       = err_reg;
  assign bus.count     = count_reg;

endmodule
